// File: rtl/wallace_mac_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wallace_mac_pipe : 3-stage Baugh-Wooley / Wallace-tree multiply-accumulate
// Revision 1.0
// ---------------------------------------------------------------------------
module wallace_mac_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_result,
  output logic                 out_ovf
);

  localparam int PW   = 2*WIDTH;
  localparam int NROW = WIDTH + 1;

  function automatic int calc_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      if (r > 2) begin
        r = 2*(r/3) + (r%3);
        n++;
      end
    end
    return n;
  endfunction

  localparam int NLVL = calc_levels(NROW);

  logic                 stall;
  logic                 v1_q, sgn1_q, acc1_q;
  logic [WIDTH-1:0]     a1_q, b1_q;
  logic                 v2_q, sgn2_q, acc2_q;
  logic [PW-1:0]        sum2_q, car2_q;
  logic                 v3_q, ovf_q;
  logic [ACC_WIDTH-1:0] acc_q;

  logic [PW-1:0]        tree [0:NLVL][0:NROW-1];
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext, base, result_d;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 ovf_d;

  assign stall      = v3_q & ~out_ready;
  assign in_ready   = rst_n & ~stall;
  assign out_valid  = v3_q;
  assign out_result = acc_q;
  assign out_ovf    = ovf_q;

  // Row WIDTH carries the Baugh-Wooley correction 2^WIDTH + 2^(2*WIDTH-1).
  always_comb begin
    for (int l = 0; l <= NLVL; l++) begin
      for (int r = 0; r < NROW; r++) begin
        tree[l][r] = '0;
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        tree[0][j][i+j] = (a1_q[i] & b1_q[j]) ^
                          (sgn1_q & ((i == WIDTH-1) ^ (j == WIDTH-1)));
      end
    end
    if (sgn1_q) begin
      tree[0][WIDTH][WIDTH]  = 1'b1;
      tree[0][WIDTH][PW-1]   = 1'b1;
    end
    for (int l = 0; l < NLVL; l++) begin
      for (int g = 0; g < NROW/3; g++) begin
        tree[l+1][2*g]   = tree[l][3*g] ^ tree[l][3*g+1] ^ tree[l][3*g+2];
        tree[l+1][2*g+1] = ((tree[l][3*g]   & tree[l][3*g+1]) |
                            (tree[l][3*g]   & tree[l][3*g+2]) |
                            (tree[l][3*g+1] & tree[l][3*g+2])) << 1;
      end
      for (int k = 0; k < NROW%3; k++) begin
        tree[l+1][2*(NROW/3)+k] = tree[l][3*(NROW/3)+k];
      end
    end
  end

  assign prod = sum2_q + car2_q;

  if (ACC_WIDTH > PW) begin : g_ext_wide
    assign prod_ext = sgn2_q ? {{(ACC_WIDTH-PW){prod[PW-1]}}, prod}
                             : {{(ACC_WIDTH-PW){1'b0}}, prod};
  end else begin : g_ext_none
    assign prod_ext = prod;
  end

  // acc_q always equals the last completed result, so forwarding is implicit.
  assign base     = acc2_q ? acc_q : '0;
  assign sum_ext  = {1'b0, base} + {1'b0, prod_ext};
  assign result_d = sum_ext[ACC_WIDTH-1:0];
  assign ovf_d    = acc2_q & (sgn2_q ?
                    ((base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &
                     (sum_ext[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                    : sum_ext[ACC_WIDTH]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      sgn1_q <= 1'b0;
      acc1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      v2_q   <= 1'b0;
      sgn2_q <= 1'b0;
      acc2_q <= 1'b0;
      sum2_q <= '0;
      car2_q <= '0;
      v3_q   <= 1'b0;
      ovf_q  <= 1'b0;
      acc_q  <= '0;
    end else if (!stall) begin
      v1_q   <= in_valid;
      sgn1_q <= in_signed;
      acc1_q <= in_acc;
      a1_q   <= in_a;
      b1_q   <= in_b;
      v2_q   <= v1_q;
      sgn2_q <= sgn1_q;
      acc2_q <= acc1_q;
      sum2_q <= tree[NLVL][0];
      car2_q <= tree[NLVL][1];
      v3_q   <= v2_q;
      if (v2_q) begin
        acc_q <= result_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wallace_mac_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wallace_mac_pipe : directed self-checking bench for wallace_mac_pipe
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wallace_mac_pipe;

  localparam int W  = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_signed, in_acc;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_result;
  logic          out_ovf;

  always #5 clk = ~clk;

  wallace_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_acc     (in_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  typedef struct packed {
    logic [AW-1:0] res;
    logic          ovf;
  } exp_t;

  exp_t          expq[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] hold_r;
  logic          hold_o;
  logic [AW:0]   model;

  logic [W-1:0]  v5a [0:9] = '{8'd10, 8'd3, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'd200, 8'd1, 8'h02, 8'h00};
  logic [W-1:0]  v5b [0:9] = '{8'd20, 8'd7, 8'h02, 8'h7F, 8'h7F, 8'h7F, 8'd100, 8'd1, 8'hFD, 8'h55};
  logic          v5s [0:9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic          v5c [0:9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [AW-1:0] v5r [0:9] = '{24'h0000C8, 24'h0000DD, 24'hFFFFFE, 24'h003EFF, 24'hFFC080,
                               24'hFF8100, 24'h004E20, 24'h004E21, 24'h004E1B, 24'h000000};

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic acc, input logic track, input logic [AW-1:0] res,
                      input logic ovf);
    int guard;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_acc    = acc;
    in_valid  = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (!in_ready) chk("send_timeout", {23'b0, in_ready}, 24'd1);
    if (track) expq.push_back('{res: res, ovf: ovf});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((expq.size() != 0 || out_valid) && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_left", expq.size(), 24'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", {23'b0, out_valid}, 24'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("result", out_result, mon_e.res);
        chk("ovf", {23'b0, out_ovf}, {23'b0, mon_e.ovf});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_acc    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {23'b0, out_valid}, 24'd0);
    chk("rst_out_result", out_result, 24'd0);
    chk("rst_out_ovf", {23'b0, out_ovf}, 24'd0);
    chk("rst_in_ready", {23'b0, in_ready}, 24'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {23'b0, in_ready}, 24'd1);
    tick();

    // 255x255 unsigned and its pipeline latency
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 24'h00FE01, 1'b0);
    in_valid = 1'b0;
    chk("lat_after_N", {23'b0, out_valid}, 24'd0);
    tick();
    chk("lat_after_N1", {23'b0, out_valid}, 24'd0);
    tick();
    chk("lat_at_N3", {23'b0, out_valid}, 24'd1);
    chk("lat_result", out_result, 24'h00FE01);
    drain();

    // signed products
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 24'h004000, 1'b0);
    send(8'hFF, 8'h05, 1'b1, 1'b0, 1'b1, 24'hFFFFFB, 1'b0);
    in_valid = 1'b0;
    drain();

    // back-to-back accumulate chain
    send(8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 24'd12, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b1, 1'b1, 24'd42, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 24'd46, 1'b0);
    in_valid = 1'b0;
    chk("chain_c0", out_result, 24'd12);
    tick();
    chk("chain_c1", out_result, 24'd42);
    tick();
    chk("chain_c2", out_result, 24'd46);
    drain();

    // unsigned overflow after 259 accumulations of 255x255
    model = '0;
    for (int k = 1; k <= 259; k++) begin
      model = {1'b0, model[AW-1:0]} + 25'd65025;
      if (k == 258)
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 24'd16776450, 1'b0);
      else if (k == 259)
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 24'd64259, 1'b1);
      else
        send(8'hFF, 8'hFF, 1'b0, (k != 1), 1'b1, model[AW-1:0], model[AW]);
    end
    in_valid = 1'b0;
    drain();

    // backpressure: 5-cycle stall in the middle of a 10-beat stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(v5a[i], v5b[i], v5s[i], v5c[i], 1'b1, v5r[i], 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        hold_r = out_result;
        hold_o = out_ovf;
        chk("stall_entry_valid", {23'b0, out_valid}, 24'd1);
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("stall_in_ready", {23'b0, in_ready}, 24'd0);
          chk("stall_out_valid", {23'b0, out_valid}, 24'd1);
          chk("stall_out_result", out_result, hold_r);
          chk("stall_out_ovf", {23'b0, out_ovf}, {23'b0, hold_o});
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with three beats in flight
    out_ready = 1'b0;
    send(8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    send(8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
    send(8'd4, 8'd4, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
    in_valid = 1'b0;
    chk("inflight_valid", {23'b0, out_valid}, 24'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", {23'b0, out_valid}, 24'd0);
    chk("midrst_out_result", out_result, 24'd0);
    chk("midrst_out_ovf", {23'b0, out_ovf}, 24'd0);
    chk("midrst_in_ready", {23'b0, in_ready}, 24'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send(8'd7, 8'd9, 1'b0, 1'b1, 1'b1, 24'd63, 1'b0);
    in_valid = 1'b0;
    drain();
    repeat (6) tick();
    chk("quiet_after_rst", {23'b0, out_valid}, 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
